// File: rtl/pin_entry_keypad.sv
// pin_entry_keypad: gathers two BCD digits from the gate keypad. It packs
// them into an 8-bit PIN and raises a one-cycle enterPin strobe for the
// gate FSM. Partial entries are dropped on clear, on an idle timeout, or
// when the vehicle leaves.
module pin_entry_keypad #(
  parameter int TIMEOUT_CYCLES = 50,
  parameter int CNT_W          = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Vehiculo,
  input  logic [3:0] Tecla,
  input  logic       TeclaValida,
  input  logic       Aceptar,
  input  logic       Borrar,
  output logic [7:0] Pin,
  output logic       enterPin,
  output logic [1:0] Digitos,
  output logic       ErrorTecla
);

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    CAPTURA = 2'd1,
    ENVIO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMR_MAX  = '1;

  state_t           state_q, state_d;
  logic [7:0]       buf_q, buf_d;
  logic [1:0]       dig_q, dig_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [7:0]       pin_q, pin_d;
  logic             enter_q, enter_d;
  logic             err_q, err_d;

  // Next-state logic: key handling with priority Borrar > Aceptar > TeclaValida.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    buf_d   = buf_q;
    dig_d   = dig_q;
    tmr_d   = tmr_q;
    pin_d   = pin_q;
    enter_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      ESPERA: begin
        buf_d = '0;
        dig_d = '0;
        tmr_d = '0;
        if (Vehiculo) state_d = CAPTURA;
      end

      CAPTURA: begin
        if (!Vehiculo) begin
          // The vehicle left: drop any partial entry and wait for the next one.
          buf_d   = '0;
          dig_d   = '0;
          tmr_d   = '0;
          state_d = ESPERA;
        end else if (Borrar) begin
          buf_d = '0;
          dig_d = '0;
          tmr_d = '0;
        end else if (Aceptar) begin
          if (dig_q == 2'd2) begin
            pin_d   = buf_q;
            enter_d = 1'b1;
            state_d = ENVIO;
          end else begin
            err_d = 1'b1;
          end
          buf_d = '0;
          dig_d = '0;
          tmr_d = '0;
        end else if (TeclaValida) begin
          tmr_d = '0;
          if (Tecla <= 4'd9) begin
            // Shift the new digit in. A third digit pushes the oldest one out.
            buf_d = {buf_q[3:0], Tecla};
            dig_d = (dig_q == 2'd2) ? 2'd2 : dig_q + 2'd1;
          end else begin
            err_d = 1'b1;
          end
        end else if (dig_q == 2'd0) begin
          tmr_d = '0;
        end else if (tmr_q == TMR_LAST) begin
          // Idle too long with a partial entry: discard it silently.
          buf_d = '0;
          dig_d = '0;
          tmr_d = '0;
        end else if (tmr_q != TMR_MAX) begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      ENVIO: begin
        // This is the single enterPin cycle. Keys pressed now are ignored.
        state_d = Vehiculo ? CAPTURA : ESPERA;
      end

      default: begin
        state_d = ESPERA;
        buf_d   = '0;
        dig_d   = '0;
        tmr_d   = '0;
      end
    endcase
  end

  // State and registered outputs. Reset is asynchronous and active-low.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ESPERA;
      buf_q   <= '0;
      dig_q   <= '0;
      tmr_q   <= '0;
      pin_q   <= '0;
      enter_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values together.
      state_q <= state_d;
      buf_q   <= buf_d;
      dig_q   <= dig_d;
      tmr_q   <= tmr_d;
      pin_q   <= pin_d;
      enter_q <= enter_d;
      err_q   <= err_d;
    end
  end

  assign Pin        = pin_q;
  assign enterPin   = enter_q;
  assign Digitos    = dig_q;
  assign ErrorTecla = err_q;

endmodule
